// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising serial LFSR sequence checker
//
// Sits downstream of an LFSR and consumes its serial output one bit per
// bit_valid. It fills a 5-bit history (HUNT), then confirms that
// successive bits follow the tap recurrence (VERIFY). After that it
// free-runs on its own predictions (LOCKED, flywheel) and counts every
// received bit that disagrees.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bit_valid  in   bit_in is valid this cycle
//   bit_in     in   serial data bit from the LFSR
//   taps       in   5-bit tap vector shared with the LFSR (taps[0] unused)
//   resync     in   synchronous: back to HUNT, discard the current bit
//   clear      in   synchronous: zero err_count
//   locked     out  checker is in LOCKED
//   err_pulse  out  one-cycle pulse for a mismatched bit while LOCKED
//   lock_lost  out  one-cycle pulse on the LOCKED -> HUNT transition
//   err_count  out  saturating count of errors seen while LOCKED
`timescale 1ns/1ps

module lfsr_checker #(
   parameter int LOCK_CNT    = 8,
   parameter int WINDOW      = 32,
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16,
   parameter int FB_XNOR     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic [4:0]       taps,
   input  logic             resync,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic             lock_lost,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [7:0]       LOCK_V   = 8'(LOCK_CNT);
   localparam logic [15:0]      WINDOW_V = 16'(WINDOW);
   localparam logic [15:0]      LOSS_V   = 16'(LOSS_THRESH);
   localparam logic             FB_INV   = (FB_XNOR != 0);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  h_q, h_d;
   logic [2:0]  fill_q, fill_d;
   logic [7:0]  match_q, match_d;
   logic [15:0] win_bits_q, win_bits_d;
   logic [15:0] win_errs_q, win_errs_d;
   logic [ERR_W-1:0] err_count_d;
   logic        err_pulse_d;
   logic        lock_lost_d;

   logic        pred;
   logic        err_bit;
   logic        is_match;
   logic [7:0]  match_inc;
   logic [15:0] win_bits_inc;
   logic [15:0] win_errs_base;

   // taps[0] has no history bit to pair with; kept on the port so the
   // checker can share the LFSR's tap bus unchanged.
   logic unused_tap0;
   assign unused_tap0 = taps[0];

   // Next bit predicted from the four older history bits; h[0] does not
   // take part in the recurrence.
   assign pred         = (^(taps[4:1] & h_q[4:1])) ^ FB_INV;
   assign match_inc    = match_q + 8'd1;
   assign win_bits_inc = win_bits_q + 16'd1;

   // ------------------------------------------------------------------
   // Next-state / next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      h_d           = h_q;
      fill_d        = fill_q;
      match_d       = match_q;
      win_bits_d    = win_bits_q;
      win_errs_d    = win_errs_q;
      err_bit       = 1'b0;
      lock_lost_d   = 1'b0;
      is_match      = 1'b0;
      win_errs_base = win_errs_q;

      if (resync) begin
         // The current bit is dropped entirely, even if bit_valid is high.
         if (state_q == ST_LOCKED) begin
            lock_lost_d = 1'b1;
         end
         state_d    = ST_HUNT;
         fill_d     = 3'd0;
         match_d    = 8'd0;
         win_bits_d = 16'd0;
         win_errs_d = 16'd0;
      end else if (bit_valid) begin
         case (state_q)
            ST_HUNT: begin
               h_d = {h_q[3:0], bit_in};
               if (fill_q == 3'd4) begin
                  fill_d  = 3'd0;
                  match_d = 8'd0;
                  state_d = ST_VERIFY;
               end else begin
                  fill_d = fill_q + 3'd1;
               end
            end

            ST_VERIFY: begin
               h_d      = {h_q[3:0], bit_in};
               is_match = (bit_in == pred);
               // An all-zero history matches any zero stream trivially, so
               // such matches neither build nor break confidence.
               if (is_match && (h_d != 5'd0)) begin
                  match_d = match_inc;
                  if (match_inc == LOCK_V) begin
                     state_d    = ST_LOCKED;
                     win_bits_d = 16'd0;
                     win_errs_d = 16'd0;
                  end
               end else if (!is_match) begin
                  match_d = 8'd0;
               end
            end

            ST_LOCKED: begin
               // Flywheel: history follows the prediction, so a corrupted
               // bit costs exactly one error and does not propagate.
               h_d     = {h_q[3:0], pred};
               err_bit = (bit_in != pred);
               if (win_bits_inc == WINDOW_V) begin
                  win_bits_d    = 16'd0;
                  win_errs_base = 16'd0;
               end else begin
                  win_bits_d    = win_bits_inc;
                  win_errs_base = win_errs_q;
               end
               // The current bit's error lands in the (possibly new) window.
               win_errs_d = win_errs_base + {15'd0, err_bit};
               if (win_errs_d >= LOSS_V) begin
                  state_d     = ST_HUNT;
                  lock_lost_d = 1'b1;
                  fill_d      = 3'd0;
               end
            end

            default: begin
               state_d = ST_HUNT;
               fill_d  = 3'd0;
            end
         endcase
      end

      err_pulse_d = err_bit;

      // clear wins over the old count but not over an error in the same
      // cycle, which then becomes the first error counted.
      if (clear) begin
         err_count_d = err_bit ? ERR_ONE : '0;
      end else if (err_bit && (err_count != ERR_MAX)) begin
         err_count_d = err_count + ERR_ONE;
      end else begin
         err_count_d = err_count;
      end
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_HUNT;
         h_q        <= 5'd0;
         fill_q     <= 3'd0;
         match_q    <= 8'd0;
         win_bits_q <= 16'd0;
         win_errs_q <= 16'd0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         lock_lost  <= 1'b0;
         err_count  <= '0;
      end else begin
         state_q    <= state_d;
         h_q        <= h_d;
         fill_q     <= fill_d;
         match_q    <= match_d;
         win_bits_q <= win_bits_d;
         win_errs_q <= win_errs_d;
         locked     <= (state_d == ST_LOCKED);
         err_pulse  <= err_pulse_d;
         lock_lost  <= lock_lost_d;
         err_count  <= err_count_d;
      end
   end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial sequence checker that sits directly downstream of `lfsr`. It consumes the LFSR's serial `out` bit, one bit per `advance`, and self-synchronises to the sequence. Once locked, it predicts each next bit from its own history and counts bit errors. It reports lock status, per-bit error pulses and a saturating error count for link/BIST monitoring.

## Interface
Parameters:
- `LOCK_CNT`, default 8: consecutive non-zero-history matches required to declare lock (1..255).
- `WINDOW`, default 32: bits per loss-of-lock window (2..65535).
- `LOSS_THRESH`, default 4: errors within one window that force loss of lock (1..WINDOW).
- `ERR_W`, default 16: width of `err_count`.
- `FB_XNOR`, default 0: 1 inverts the feedback prediction (XNOR-form LFSR).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: **asynchronous, active-low reset**.
- `bit_valid` in 1: `bit_in` is valid this cycle; tie to the LFSR's `advance`, delayed one cycle.
- `bit_in` in 1: serial bit; connect to the LFSR's `out`.
- `taps` in 5: same tap vector driven into the LFSR. `taps[0]` is ignored.
- `resync` in 1: synchronous; forces HUNT and discards the current bit.
- `clear` in 1: synchronous; zeroes `err_count`.
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle pulse, registered, for a mismatched bit while LOCKED.
- `lock_lost` out 1: one-cycle pulse on the LOCKED -> HUNT transition.
- `err_count` out ERR_W: errors while LOCKED, saturating at all-ones.

## Operation
- **History:** `h[4:0]`, where `h[0]` is the most recent accepted bit. A shift is `h <= {h[3:0], s}`.
- **Prediction:** `p = ^(taps[4:1] & h[4:1])`, XOR-ed with `FB_XNOR`. This equals the LFSR recurrence `b[n] = XOR over i=1..4 of taps[i]&b[n-1-i]`.
- **FSM states:** HUNT, VERIFY, LOCKED. Reset state is HUNT. State changes only on cycles where `bit_valid=1`, except for `resync`.
- **HUNT:**
  - Each valid bit shifts in `s=bit_in` and increments `fill`, a 3-bit counter.
  - On the 5th bit: `fill` is cleared, `match_cnt` is cleared, and the FSM goes to VERIFY.
- **VERIFY:**
  - Each valid bit shifts in `s=bit_in`.
  - Match is `bit_in==p`. If the match occurs and the post-shift `h` is non-zero, `match_cnt` increments.
  - A mismatch clears `match_cnt` (self-resync on received data).
  - A match with all-zero history neither increments nor clears `match_cnt`.
  - When `match_cnt` reaches `LOCK_CNT`: the FSM goes to LOCKED, and `win_bits` and `win_errs` are cleared.
- **LOCKED (flywheel):**
  - Each valid bit shifts in `s=p`, the prediction rather than `bit_in`.
  - On mismatch: `err_pulse=1` on the next cycle, `err_count` increments (saturating), and `win_errs` increments.
  - `win_bits` counts valid bits. When it reaches `WINDOW`, both `win_bits` and `win_errs` reset to 0 in that same cycle; the current bit's error counts toward the new window.
  - If the post-increment `win_errs` is at least `LOSS_THRESH`: the FSM goes to HUNT, `lock_lost` pulses, and `fill` is cleared. `err_count` is kept.
- **Priority:** `resync` > `bit_valid` processing.
  - `resync` sends the FSM to HUNT and clears `fill`, `match_cnt` and the window counters.
  - If the FSM was LOCKED when `resync` is asserted, `lock_lost` pulses.
  - `err_count` is unaffected by `resync`.
- **`clear` with an error in the same cycle:** `err_count` becomes 1. Otherwise `clear` sets `err_count` to 0.
- `bit_valid=0` is a full hold of state, history and counters.

## Timing
- **Reset values:** all outputs and internal state are 0, and the FSM is in HUNT.
  - `rst_n` assertion takes effect immediately and asynchronously.
  - Deassertion is sampled at the next `clk` edge.
- **Registered outputs:** all outputs are registered. `err_pulse` and `lock_lost` rise one cycle after the bit that caused them.
- **Lock latency:** minimum 5 + `LOCK_CNT` valid bits from HUNT. `locked` rises on the clock edge that accepts the `LOCK_CNT`-th qualifying match.
- **Loss latency:** `locked` falls on the same edge that registers `lock_lost`.
- **Throughput:** one bit per cycle sustained, with no backpressure.
- **Reset mid-operation:** `rst_n` low during LOCKED drops `locked` asynchronously, does not pulse `lock_lost`, and zeroes `err_count`.

## Test plan
- **Reset:** hold `rst_n=0`, then release -> `locked=0`, `err_pulse=0`, `lock_lost=0`, `err_count=0`; 10 cycles with `bit_valid=0` -> nothing changes.
- **Clean acquisition:** drive `lfsr` with `taps=5'b10010`, seed `5'b00001`, `advance=1` every cycle -> `locked=1` after exactly 13 valid bits; `err_count=0` after 200 bits.
- **Single error:** while locked, flip one bit -> one `err_pulse`, `err_count=1`, `locked` stays 1; the following correct bits produce no further pulses (flywheel).
- **Loss of lock:** flip 4 bits within one 32-bit window -> `lock_lost` pulse, `locked=0`, `err_count=4`; clean stream afterwards -> re-lock after 13 bits.
- **Degenerate stream:** all-zero stream for 100 bits -> `locked` stays 0. Then `resync` and `bit_valid` in the same cycle while locked -> bit discarded, `lock_lost` pulses, FSM in HUNT.
- **Clear, saturation and async reset:** `clear` in the same cycle as an error -> `err_count=1`; with `ERR_W=4`, 20 errors -> `err_count=15`; `rst_n` pulse mid-cycle while locked -> `locked=0` before the next edge.
